// File: rtl/shift_register_serdes.sv
// shift_register_serdes: parallel-load shift register with framed serial shifting and single-step rotate
module shift_register_serdes #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             rotate,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] pout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d, shl, rot;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  assign shl  = MSB_FIRST ? {reg_q[WIDTH-2:0], sin} : {sin, reg_q[WIDTH-1:1]};
  assign rot  = MSB_FIRST ? {reg_q[WIDTH-2:0], reg_q[WIDTH-1]} : {reg_q[0], reg_q[WIDTH-1:1]};
  assign sout = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];
  assign pout = reg_q;
  assign busy = state_q == SHIFT;
  assign done = done_q;
  // state, data register, bit counter and done pulse; reset aborts any frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // IDLE commands by priority load > start > rotate; SHIFT runs WIDTH shifts then pulses done
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (load) reg_d = pin;
      else if (start) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end else if (rotate) reg_d = rot;
    end else begin
      reg_d = shl;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shift_register_serdes.sv
// tb_shift_register_serdes: scoreboard bench for MSB-first and LSB-first instances
module tb_shift_register_serdes;
  logic clk = 1'b0, reset = 1'b0, load = 1'b0, start = 1'b0, rotate = 1'b0, sin = 1'b0;
  logic [7:0] pin = '0;
  logic sout_m, busy_m, done_m, sout_l, busy_l, done_l;
  logic [7:0] pout_m, pout_l;
  logic sq[$], lq[$];
  logic [7:0] pq[$], lpq[$];
  logic [7:0] m;
  int n_chk = 0, n_pass = 0, cyc = 0, last_done = 0, first_done = 0;

  shift_register_serdes #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load(load), .pin(pin), .start(start), .rotate(rotate),
    .sin(sin), .sout(sout_m), .pout(pout_m), .busy(busy_m), .done(done_m)
  );
  shift_register_serdes #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load(load), .pin(pin), .start(start), .rotate(rotate),
    .sin(sin), .sout(sout_l), .pout(pout_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] sd);
    for (int k = 0; k < 8; k++) sq.push_back(m[7-k]);
    pq.push_back(sd);
    m = sd;
  endtask

  task automatic frame(input logic [7:0] sd, input bit noise, input bit hold);
    for (int k = 0; k < 8; k++) begin
      sin    = sd[7-k];
      load   = noise && k == 3;
      rotate = noise && k == 3;
      start  = hold || (noise && k == 3);
      if (noise && k == 3) pin = 8'hFF;
      check("busy_in_frame", busy_m, 1'b1);
      check("done_in_frame", done_m, 1'b0);
      if (sq.size() != 0) check("sout", sout_m, sq.pop_front());
      if (lq.size() != 0) check("lsb_sout", sout_l, lq.pop_front());
      tick();
    end
    sin = 1'b0; load = 1'b0; rotate = 1'b0; start = hold;
    check("busy_at_done", busy_m, 1'b0);
    check("done_pulse", done_m, 1'b1);
    last_done = cyc;
    if (pq.size() != 0) check("pout_frame", pout_m, pq.pop_front());
    if (lpq.size() != 0) check("lsb_pout_frame", pout_l, lpq.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_pout", pout_m, 8'h00);
    check("rst_busy", busy_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_sout", sout_m, 1'b0);
    #2 reset = 1'b1;
    tick();
    // frame: load A5, shift in 3C
    pin = 8'hA5; load = 1'b1; tick(); load = 1'b0; m = 8'hA5;
    check("load_a5", pout_m, 8'hA5);
    expect_frame(8'h3C);
    start = 1'b1; tick(); start = 1'b0;
    frame(8'h3C, 1'b0, 1'b0);
    tick();
    check("done_clears", done_m, 1'b0);
    // rotate
    pin = 8'h81; load = 1'b1; tick(); load = 1'b0;
    rotate = 1'b1; tick();
    check("rot1", pout_m, 8'h03);
    check("lsb_rot1", pout_l, 8'hC0);
    tick(); rotate = 1'b0;
    check("rot2", pout_m, 8'h06);
    check("lsb_rot2", pout_l, 8'h60);
    // load beats start; commands ignored mid-frame
    pin = 8'h5A; load = 1'b1; start = 1'b1; tick(); load = 1'b0; start = 1'b0; m = 8'h5A;
    check("prio_pout", pout_m, 8'h5A);
    check("prio_busy", busy_m, 1'b0);
    expect_frame(8'h96);
    start = 1'b1; tick(); start = 1'b0;
    frame(8'h96, 1'b1, 1'b0);
    tick();
    check("noise_no_restart", busy_m, 1'b0);
    // back-to-back frames with start held through done
    expect_frame(8'hC3);
    start = 1'b1; tick();
    frame(8'hC3, 1'b0, 1'b1);
    first_done = last_done;
    expect_frame(8'h2D);
    tick(); start = 1'b0;
    check("b2b_busy", busy_m, 1'b1);
    check("b2b_done_low", done_m, 1'b0);
    frame(8'h2D, 1'b0, 1'b0);
    check("b2b_spacing", last_done - first_done, 9);
    tick();
    // reset mid-frame
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sin = 1'b1;
      check("pre_rst_sout", sout_m, m[7-k]);
      tick();
    end
    sin = 1'b0;
    reset = 1'b0; #1;
    check("mid_rst_pout", pout_m, 8'h00);
    check("mid_rst_busy", busy_m, 1'b0);
    check("mid_rst_sout", sout_m, 1'b0);
    check("mid_rst_done", done_m, 1'b0);
    tick(); reset = 1'b1;
    pin = 8'hFF; load = 1'b1; tick(); load = 1'b0;
    check("post_rst_load", pout_m, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      check("no_done_after_rst", done_m, 1'b0);
      tick();
    end
    // LSB-first instance with constant sin=1
    pin = 8'h01; load = 1'b1; tick(); load = 1'b0; m = 8'h01;
    lq.push_back(1'b1);
    for (int k = 0; k < 7; k++) lq.push_back(1'b0);
    lpq.push_back(8'hFF);
    expect_frame(8'hFF);
    start = 1'b1; tick(); start = 1'b0;
    frame(8'hFF, 1'b0, 1'b0);
    check("queues_drained", sq.size() + lq.size() + pq.size() + lpq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_register_serdes.md
SHIFT_REGISTER_SERDES -- requirements
Module: shift_register_serdes

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = shift toward MSB (serial out at bit WIDTH-1), 0 = shift toward LSB (serial out at bit 0).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load  input  1  parallel-load request, honoured only in IDLE.
REQ-006 The block SHALL have port pin  input  WIDTH  parallel load data.
REQ-007 The block SHALL have port start  input  1  begin automatic WIDTH-bit shift frame, honoured only in IDLE.
REQ-008 The block SHALL have port rotate  input  1  single-step circular shift, honoured only in IDLE.
REQ-009 The block SHALL have port sin  input  1  serial input, sampled during the frame.
REQ-010 The block SHALL have port sout  output  1  serial output.
REQ-011 The block SHALL have port pout  output  WIDTH  register contents.
REQ-012 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-015 In IDLE, priority per clock edge SHALL be load > start > rotate > hold.
REQ-016 On load in IDLE, the register SHALL take pin at the edge; the state SHALL remain IDLE.
REQ-017 On start in IDLE (load low), the state SHALL become SHIFT, the bit counter SHALL clear to 0, and the register SHALL be unchanged at that edge.
REQ-018 On rotate in IDLE (load, start low), the register SHALL rotate one position: MSB_FIRST=1 gives {R[WIDTH-2:0],R[WIDTH-1]}; MSB_FIRST=0 gives {R[0],R[WIDTH-1:1]}.
REQ-019 In SHIFT, each edge SHALL shift one position in the MSB_FIRST direction, inserting sin at the vacated end (bit 0 if MSB_FIRST=1, bit WIDTH-1 otherwise), and SHALL increment the counter.
REQ-020 The edge performing the WIDTH-th shift SHALL return the state to IDLE and set done=1; done SHALL clear on the next edge.
REQ-021 Latency: start sampled at edge 0; shifts at edges 1..WIDTH; busy high from edge 0 to edge WIDTH; done high for the cycle after edge WIDTH.
REQ-022 sout SHALL be combinational from the register: R[WIDTH-1] if MSB_FIRST=1, else R[0]; before shift edge k (k=1..WIDTH) sout SHALL present original bit WIDTH-k (MSB_FIRST=1) or bit k-1 (MSB_FIRST=0).
REQ-023 pout SHALL equal the register at all times; busy SHALL equal (state==SHIFT).
REQ-024 load, start and rotate SHALL be ignored while busy=1.
REQ-025 start asserted during the done cycle (IDLE) SHALL be accepted, giving back-to-back frames with one non-shifting cycle between them.
REQ-026 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-027 reset low SHALL asynchronously force register=0, state=IDLE, counter=0, done=0, busy=0, sout=0, pout=0.
REQ-028 reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block SHALL accept a new command on the first edge.

Verification
REQ-029 Frame: WIDTH=8, MSB_FIRST=1, load 0xA5, start, drive sin MSB-first as 0x3C -> sout 1,0,1,0,0,1,0,1; busy high 9 edges; done one cycle; pout=0x3C.
REQ-030 Rotate: load 0x81, rotate one cycle -> pout=0x03; a second rotate -> 0x06.
REQ-031 Priority/ignore: load=start=1 with pin=0x5A -> pout=0x5A, busy=0; start mid-frame -> no extra shift, done after exactly 8 shifts.
REQ-032 Back-to-back: start held high through done cycle -> second frame begins, busy low exactly one cycle, two done pulses 9 cycles apart.
REQ-033 Reset mid-frame: assert reset after 3 shifts -> pout=0, busy=0, done never pulses; next load 0xFF -> pout=0xFF.
REQ-034 LSB-first: MSB_FIRST=0, load 0x01, start, sin=1 constant -> sout 1 then 0 x7; final pout=0xFF.
